// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-control inputs, instruction-memory handshake and IF/ID outputs.
// master = fetch stage, slave = memory/hazard/decode environment.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic            fetch_stall;

    modport master (
        input  pc_write, ifid_write, ifid_flush, branch_taken, branch_target,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output ifid_pc, ifid_instr, ifid_valid, fetch_stall
    );

    modport slave (
        output pc_write, ifid_write, ifid_flush, branch_taken, branch_target,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  ifid_pc, ifid_instr, ifid_valid, fetch_stall
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, a one-word buffer and the IF/ID register.
// Latency: request cycle -> IF/ID 3 cycles later with a 1-cycle memory; no rvalid bypass.
// Backpressure: pc_write/ifid_write low parks the fetched word in the buffer; redirects drop stale responses.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_req_pc, w_req_pc_nxt;
    logic [31:0]     r_buf_instr, w_buf_instr_nxt;
    logic            r_drop, w_drop_nxt;

    logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_nxt;
    logic [31:0]     r_ifid_instr, w_ifid_instr_nxt;
    logic            r_ifid_valid, w_ifid_valid_nxt;

    logic w_redirect;
    logic w_accept;
    logic w_resp;
    logic w_handoff;

    assign w_redirect = bus.branch_taken;
    assign w_accept   = (r_state == S_REQ)  && bus.imem_ready;
    assign w_resp     = (r_state == S_WAIT) && bus.imem_rvalid;
    assign w_handoff  = (r_state == S_FULL) && bus.pc_write && bus.ifid_write &&
                        !bus.ifid_flush && !w_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_pc_nxt    = r_req_pc;
        w_buf_instr_nxt = r_buf_instr;
        w_drop_nxt      = r_drop;

        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_req_pc_nxt = r_pc;
                    w_state_nxt  = S_WAIT;
                    // Request already left for the old address; its response must be thrown away.
                    w_drop_nxt   = w_redirect;
                end
            end
            S_WAIT: begin
                if (w_resp) begin
                    if (!r_drop && !w_redirect) begin
                        w_buf_instr_nxt = bus.imem_rdata;
                        w_state_nxt     = S_FULL;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end
                end else if (w_redirect) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_FULL: begin
                if (w_redirect || w_handoff) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_drop_nxt  = 1'b0;
            end
        endcase

        if (w_redirect) begin
            w_pc_nxt = bus.branch_target;
        end else if (w_handoff) begin
            w_pc_nxt = r_req_pc + XLEN'(4);
        end
    end

    always_comb begin
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;

        if (bus.ifid_flush || w_redirect) begin
            w_ifid_pc_nxt    = '0;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_valid_nxt = 1'b0;
        end else if (bus.ifid_write) begin
            if (w_handoff) begin
                w_ifid_pc_nxt    = r_req_pc;
                w_ifid_instr_nxt = r_buf_instr;
                w_ifid_valid_nxt = 1'b1;
            end else begin
                w_ifid_pc_nxt    = '0;
                w_ifid_instr_nxt = NOP_INSTR;
                w_ifid_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    assign bus.imem_req    = rst && (r_state == S_REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.fetch_stall = (r_state != S_FULL);
    assign bus.ifid_pc     = r_ifid_pc;
    assign bus.ifid_instr  = r_ifid_instr;
    assign bus.ifid_valid  = r_ifid_valid;

endmodule
